// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station_if
// Description : Bundles the reservation station's dispatch, CDB snoop, flush
//               and ALU issue signals into a single interface.
//               master : decoder / RoB / CDB side (drives dispatch + CDB)
//               slave  : reservation station (drives rs_full + alu_*)
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   rdy_in, rob_clear            global enable, misprediction flush
//   rs_inst_valid, inst_*        dispatch strobe and instruction payload
//   RoB_index                    destination RoB entry of the dispatch
//   cdb_alu_*, cdb_lsb_*         common data bus broadcasts
//   rs_full                      stall back to the decoder
//   alu_*                        issued instruction to the ALU
// ============================================================================
interface reservation_station_if #(
  parameter int ROB_W = 4
);
  logic             rdy_in;
  logic             rob_clear;
  logic             rs_full;
  logic             rs_inst_valid;
  logic [5:0]       inst_op;
  logic [ROB_W-1:0] RoB_index;
  logic [31:0]      inst_val1;
  logic [31:0]      inst_val2;
  logic             inst_has_rely1;
  logic             inst_has_rely2;
  logic [ROB_W-1:0] inst_rely1;
  logic [ROB_W-1:0] inst_rely2;
  logic [31:0]      inst_imm;
  logic             cdb_alu_valid;
  logic [ROB_W-1:0] cdb_alu_rob_id;
  logic [31:0]      cdb_alu_value;
  logic             cdb_lsb_valid;
  logic [ROB_W-1:0] cdb_lsb_rob_id;
  logic [31:0]      cdb_lsb_value;
  logic             alu_valid;
  logic [5:0]       alu_op;
  logic [31:0]      alu_val1;
  logic [31:0]      alu_val2;
  logic [31:0]      alu_imm;
  logic [ROB_W-1:0] alu_rob_id;

  modport master (
    output rdy_in, rob_clear, rs_inst_valid, inst_op, RoB_index,
           inst_val1, inst_val2, inst_has_rely1, inst_has_rely2,
           inst_rely1, inst_rely2, inst_imm,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    input  rs_full, alu_valid, alu_op, alu_val1, alu_val2, alu_imm, alu_rob_id
  );

  modport slave (
    input  rdy_in, rob_clear, rs_inst_valid, inst_op, RoB_index,
           inst_val1, inst_val2, inst_has_rely1, inst_has_rely2,
           inst_rely1, inst_rely2, inst_imm,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    output rs_full, alu_valid, alu_op, alu_val1, alu_val2, alu_imm, alu_rob_id
  );
endinterface
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : ALU-side reservation station. Holds dispatched non-memory
//               instructions until both operands are available (snooping
//               the ALU and LSB CDBs) and issues the lowest-index ready entry
//               to the ALU once per cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_in   clock
//   rst_in   synchronous active-high reset
//   bus      reservation_station_if.slave (dispatch, CDBs, flush, ALU issue)
// Optional feature:
//   RS_BYPASS_EN  when defined, a fully-ready dispatch issues straight to the
//                 ALU at the next edge if no stored entry is ready.
// ============================================================================
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int RS_ADDR = 3,
  parameter int ROB_W   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  reservation_station_if.slave   bus
);

  // Entry storage
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] q1_busy;
  logic [RS_SIZE-1:0] q2_busy;
  logic [5:0]         op     [RS_SIZE];
  logic [31:0]        v1     [RS_SIZE];
  logic [31:0]        v2     [RS_SIZE];
  logic [31:0]        imm    [RS_SIZE];
  logic [ROB_W-1:0]   q1     [RS_SIZE];
  logic [ROB_W-1:0]   q2     [RS_SIZE];
  logic [ROB_W-1:0]   rob_id [RS_SIZE];
  logic [RS_ADDR:0]   free_cnt;

  // Registered ALU issue port
  logic               alu_valid;
  logic [5:0]         alu_op;
  logic [31:0]        alu_val1;
  logic [31:0]        alu_val2;
  logic [31:0]        alu_imm;
  logic [ROB_W-1:0]   alu_rob_id;

  logic [RS_SIZE-1:0] ready;
  logic               issue_hit;
  logic [RS_ADDR-1:0] issue_idx;
  logic               free_hit;
  logic [RS_ADDR-1:0] free_idx;
  logic [31:0]        d_v1;
  logic [31:0]        d_v2;
  logic               d_p1;
  logic               d_p2;
  logic               disp_ok;
  logic               bypass;
  logic               disp_write;

  assign ready = busy & ~q1_busy & ~q2_busy;

  // Lowest-index ready entry and lowest-index free entry, both from
  // registered state so a slot freed by issue is not reused this cycle.
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_hit = 1'b1;
        issue_idx = RS_ADDR'(i);
      end
      if (!busy[i]) begin
        free_hit = 1'b1;
        free_idx = RS_ADDR'(i);
      end
    end
  end

  // Same-cycle CDB capture for the incoming instruction; ALU bus wins.
  always_comb begin
    d_v1 = bus.inst_val1;
    d_p1 = bus.inst_has_rely1;
    d_v2 = bus.inst_val2;
    d_p2 = bus.inst_has_rely2;
    if (d_p1 && bus.cdb_alu_valid && bus.cdb_alu_rob_id == bus.inst_rely1) begin
      d_v1 = bus.cdb_alu_value;
      d_p1 = 1'b0;
    end else if (d_p1 && bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == bus.inst_rely1) begin
      d_v1 = bus.cdb_lsb_value;
      d_p1 = 1'b0;
    end
    if (d_p2 && bus.cdb_alu_valid && bus.cdb_alu_rob_id == bus.inst_rely2) begin
      d_v2 = bus.cdb_alu_value;
      d_p2 = 1'b0;
    end else if (d_p2 && bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == bus.inst_rely2) begin
      d_v2 = bus.cdb_lsb_value;
      d_p2 = 1'b0;
    end
  end

  // A dispatch with no free slot is illegal upstream; it is simply dropped.
  assign disp_ok = bus.rs_inst_valid && free_hit;

`ifdef RS_BYPASS_EN
  assign bypass = disp_ok && !d_p1 && !d_p2 && !issue_hit;
`else
  assign bypass = 1'b0;
`endif

  assign disp_write = disp_ok && !bypass;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy       <= '0;
      free_cnt   <= (RS_ADDR+1)'(RS_SIZE);
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_val1   <= '0;
      alu_val2   <= '0;
      alu_imm    <= '0;
      alu_rob_id <= '0;
    end else if (bus.rdy_in) begin
      if (bus.rob_clear) begin
        busy      <= '0;
        free_cnt  <= (RS_ADDR+1)'(RS_SIZE);
        alu_valid <= 1'b0;
      end else begin
        // CDB wakeup of stored entries
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && q1_busy[i]) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == q1[i]) begin
              v1[i]      <= bus.cdb_alu_value;
              q1_busy[i] <= 1'b0;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == q1[i]) begin
              v1[i]      <= bus.cdb_lsb_value;
              q1_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && q2_busy[i]) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == q2[i]) begin
              v2[i]      <= bus.cdb_alu_value;
              q2_busy[i] <= 1'b0;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == q2[i]) begin
              v2[i]      <= bus.cdb_lsb_value;
              q2_busy[i] <= 1'b0;
            end
          end
        end

        if (disp_write) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= bus.inst_op;
          v1[free_idx]      <= d_v1;
          v2[free_idx]      <= d_v2;
          q1_busy[free_idx] <= d_p1;
          q2_busy[free_idx] <= d_p2;
          q1[free_idx]      <= bus.inst_rely1;
          q2[free_idx]      <= bus.inst_rely2;
          imm[free_idx]     <= bus.inst_imm;
          rob_id[free_idx]  <= bus.RoB_index;
        end

        if (issue_hit) begin
          busy[issue_idx] <= 1'b0;
          alu_valid       <= 1'b1;
          alu_op          <= op[issue_idx];
          alu_val1        <= v1[issue_idx];
          alu_val2        <= v2[issue_idx];
          alu_imm         <= imm[issue_idx];
          alu_rob_id      <= rob_id[issue_idx];
        end else if (bypass) begin
          alu_valid  <= 1'b1;
          alu_op     <= bus.inst_op;
          alu_val1   <= d_v1;
          alu_val2   <= d_v2;
          alu_imm    <= bus.inst_imm;
          alu_rob_id <= bus.RoB_index;
        end else begin
          alu_valid <= 1'b0;
        end

        free_cnt <= free_cnt - {{RS_ADDR{1'b0}}, disp_write}
                             + {{RS_ADDR{1'b0}}, issue_hit};
      end
    end
  end

  // One slot of margin: the decoder's dispatch lands a cycle after it samples.
  assign bus.rs_full    = (free_cnt <= (RS_ADDR+1)'(1));
  assign bus.alu_valid  = alu_valid;
  assign bus.alu_op     = alu_op;
  assign bus.alu_val1   = alu_val1;
  assign bus.alu_val2   = alu_val2;
  assign bus.alu_imm    = alu_imm;
  assign bus.alu_rob_id = alu_rob_id;

endmodule
`default_nettype wire
